instruction_cache: RTL and testbench

INSTRUCTION_CACHE -- requirements
Module: instruction_cache

---
 rtl/instruction_cache_if.sv | 27 ++
 rtl/instruction_cache.sv | 117 +++++++++++
 tb/tb_instruction_cache.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/instruction_cache_if.sv
// Processor fetch port and instruction-memory line port of the instruction cache.
// slave  : the cache side (consumes proc requests, issues mem line reads).
// master : the environment side (processor IF stage plus instruction memory).
interface instruction_cache_if;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache: 2^IDX_W lines of four 32-bit words.
// Hits return the word in the same cycle; a miss stalls, fetches the whole line
// from instruction memory and replays the access from IDLE.
// Ports:
//   clk        : clock, all state on rising edge
//   proc_reset : synchronous active-high reset
//   bus        : proc_* fetch port and mem_* line port (instruction_cache_if.slave)
module instruction_cache #(
    parameter int unsigned IDX_W = 3
) (
    input  logic               clk,
    input  logic               proc_reset,
    instruction_cache_if.slave bus
);
    localparam int unsigned LINES = 1 << IDX_W;
    localparam int unsigned TAG_W = 28 - IDX_W;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [127:0]     data_q [LINES];
    logic [27:0]      miss_addr_q;

    logic [1:0]       offset;
    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic [127:0]     line_c;
    logic [6:0]       word_sel;
    logic             hit_c;
    logic             miss_latch_c;
    logic             fill_c;
    logic             unused_c;

    // Address split for the incoming fetch and for the pending fill.
    assign offset   = bus.proc_addr[1:0];
    assign index    = bus.proc_addr[IDX_W+1:2];
    assign tag      = bus.proc_addr[29:IDX_W+2];
    assign fill_idx = miss_addr_q[IDX_W-1:0];
    assign fill_tag = miss_addr_q[27:IDX_W];

    // Hit detect and word select; the read path is live even when proc_read is low.
    assign hit_c    = bus.proc_read & valid_q[index] & (tag_q[index] == tag);
    assign line_c   = data_q[index];
    assign word_sel = {offset, 5'b0_0000};

    // Write port of the processor is meaningless for an instruction cache.
    assign unused_c      = ^{bus.proc_write, bus.proc_wdata};
    assign bus.mem_write = 1'b0;
    assign bus.mem_wdata = 128'd0;

    // Next state and fetch-side outputs; reset forces the post-reset view immediately.
    always_comb begin
        state_d        = state_q;
        miss_latch_c   = 1'b0;
        fill_c         = 1'b0;
        bus.proc_stall = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_addr   = bus.proc_addr[29:2];
        bus.proc_rdata = line_c[word_sel +: 32];
        if (proc_reset) begin
            bus.proc_stall = bus.proc_read;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.proc_read && !hit_c) begin
                        bus.proc_stall = 1'b1;
                        miss_latch_c   = 1'b1;
                        state_d        = FETCH;
                    end
                end
                FETCH: begin
                    bus.proc_stall = 1'b1;
                    bus.mem_read   = 1'b1;
                    bus.mem_addr   = miss_addr_q;
                    if (bus.mem_ready) begin
                        fill_c  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Control state: FSM, valid bits and the latched miss line address.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            miss_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (miss_latch_c) begin
                miss_addr_q <= bus.proc_addr[29:2];
            end
            if (fill_c) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    // Tag/data arrays need no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (fill_c) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench for instruction_cache: directed fetch sequences with a
// queue of expected instruction words popped whenever the cache delivers one.
module tb_instruction_cache;
    logic clk;
    logic proc_reset;
    int   checks;
    int   failures;
    bit   mem_write_seen;
    logic [31:0] exp_q [$];

    instruction_cache_if bus ();

    instruction_cache #(.IDX_W(3)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .bus        (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.mem_write !== 1'b0) mem_write_seen = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Instruction memory contents: word k of line L.
    function automatic logic [31:0] word_of(input logic [27:0] line, input logic [1:0] k);
        return (32'h1111_1111 * 32'(k)) ^ {line, 4'h0};
    endfunction

    function automatic logic [127:0] line_data(input logic [27:0] line);
        return {word_of(line, 2'd3), word_of(line, 2'd2), word_of(line, 2'd1), word_of(line, 2'd0)};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Delivered word compared against the oldest expectation.
    task automatic pop_compare(input string tag);
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 64'd1, 64'd0);
        end else begin
            check(tag, 64'(bus.proc_rdata), 64'(exp_q.pop_front()));
        end
    endtask

    // Acts as instruction memory for an outstanding miss: ready after lat FETCH cycles.
    task automatic serve_fill(input logic [27:0] line, input int lat);
        bit done;
        int done_at;
        done    = 1'b0;
        done_at = 0;
        for (int i = 1; i <= 64 && !done; i++) begin
            tick();
            bus.mem_ready = 1'b0;
            @(negedge clk);
            if (!bus.proc_stall) begin
                done    = 1'b1;
                done_at = i;
            end else begin
                check("fetch_mem_read", 64'(bus.mem_read), 64'd1);
                check("fetch_mem_addr", 64'(bus.mem_addr), 64'(line));
                if (i == lat) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = line_data(line);
                end
            end
        end
        if (!done) check("fill_timeout", 64'd0, 64'd1);
        else check("fill_latency", 64'(done_at), 64'(lat + 1));
        check("after_fill_mem_read", 64'(bus.mem_read), 64'd0);
    endtask

    // One fetch of word address a; a miss is served with memory latency lat.
    task automatic fetch(input logic [29:0] a, input bit exp_miss, input int lat);
        tick();
        bus.proc_read = 1'b1;
        bus.proc_addr = a;
        exp_q.push_back(word_of(a[29:2], a[1:0]));
        @(negedge clk);
        check("first_cycle_stall", 64'(bus.proc_stall), 64'(exp_miss));
        check("first_cycle_mem_read", 64'(bus.mem_read), 64'd0);
        if (bus.proc_stall) serve_fill(a[29:2], lat);
        pop_compare("rdata");
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        mem_write_seen = 1'b0;
        proc_reset     = 1'b1;
        bus.proc_read  = 1'b1;
        bus.proc_write = 1'b0;
        bus.proc_addr  = 30'h0;
        bus.proc_wdata = 32'h0;
        bus.mem_ready  = 1'b0;
        bus.mem_rdata  = 128'd0;

        // Reset view: everything misses, memory side quiet.
        tick();
        tick();
        @(negedge clk);
        check("rst_stall_read", 64'(bus.proc_stall), 64'd1);
        check("rst_mem_read", 64'(bus.mem_read), 64'd0);
        check("rst_mem_write", 64'(bus.mem_write), 64'd0);
        check("rst_mem_wdata", 64'(bus.mem_wdata[63:0]), 64'd0);
        bus.proc_read = 1'b0;
        #1;
        check("rst_stall_noread", 64'(bus.proc_stall), 64'd0);
        tick();
        proc_reset    = 1'b0;
        bus.proc_addr = 30'h123;
        @(negedge clk);
        check("idle_stall", 64'(bus.proc_stall), 64'd0);
        check("idle_mem_read", 64'(bus.mem_read), 64'd0);
        check("idle_mem_addr", 64'(bus.mem_addr), 64'h48);

        // Cold miss on line 0, then the other three words hit back to back.
        fetch(30'h0, 1'b1, 4);
        fetch(30'h1, 1'b0, 0);
        fetch(30'h2, 1'b0, 0);
        fetch(30'h3, 1'b0, 0);

        // Conflict on index 0 evicts in both directions.
        fetch(30'h20, 1'b1, 2);
        fetch(30'h21, 1'b0, 0);
        fetch(30'h0, 1'b1, 1);
        fetch(30'h20, 1'b1, 3);

        // Redirect while the miss on 0x40 is outstanding.
        tick();
        bus.proc_read = 1'b1;
        bus.proc_addr = 30'h40;
        @(negedge clk);
        check("redir_miss", 64'(bus.proc_stall), 64'd1);
        tick();
        bus.proc_addr = 30'h4;
        @(negedge clk);
        check("redir_mem_addr0", 64'(bus.mem_addr), 64'h10);
        check("redir_mem_read0", 64'(bus.mem_read), 64'd1);
        tick();
        @(negedge clk);
        check("redir_mem_addr1", 64'(bus.mem_addr), 64'h10);
        check("redir_stall1", 64'(bus.proc_stall), 64'd1);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = line_data(28'h10);
        tick();
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check("redir_new_miss", 64'(bus.proc_stall), 64'd1);
        check("redir_idle_mem_read", 64'(bus.mem_read), 64'd0);
        check("redir_idle_mem_addr", 64'(bus.mem_addr), 64'h1);
        exp_q.push_back(word_of(28'h1, 2'd0));
        serve_fill(28'h1, 2);
        pop_compare("redir_rdata");
        fetch(30'h42, 1'b0, 0);
        fetch(30'h5, 1'b0, 0);

        // Reset sampled in FETCH together with mem_ready aborts the fill.
        tick();
        bus.proc_addr = 30'h8;
        @(negedge clk);
        check("abort_miss", 64'(bus.proc_stall), 64'd1);
        tick();
        @(negedge clk);
        check("abort_fetching", 64'(bus.mem_read), 64'd1);
        proc_reset    = 1'b1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = line_data(28'h2);
        #1;
        check("abort_rst_mem_read", 64'(bus.mem_read), 64'd0);
        check("abort_rst_stall", 64'(bus.proc_stall), 64'd1);
        tick();
        proc_reset    = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        check("abort_mem_read_after", 64'(bus.mem_read), 64'd0);
        check("abort_remiss", 64'(bus.proc_stall), 64'd1);
        exp_q.push_back(word_of(28'h2, 2'd0));
        serve_fill(28'h2, 3);
        pop_compare("abort_rdata");
        fetch(30'h40, 1'b1, 1);

        // Writes are ignored; the line keeps its memory contents.
        bus.proc_write = 1'b1;
        bus.proc_wdata = 32'hDEAD_BEEF;
        fetch(30'h41, 1'b0, 0);
        bus.proc_write = 1'b0;
        fetch(30'h41, 1'b0, 0);
        fetch(30'h9, 1'b0, 0);

        tick();
        bus.proc_read = 1'b0;
        @(negedge clk);
        check("mem_write_never", 64'(mem_write_seen), 64'd0);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
